// File: rtl/ttl_memory_cell_pkg.sv
// Shared definitions for the TTL memory cell: cell state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DEF_*_WIDTH   default parameter values used by the cell and its bench
//   cell_state_t  EMPTY / PERSIST (live, no expiry) / TIMED (live, counting down)
//   is_live()     true for any state that holds a valid entry
package ttl_memory_cell_pkg;

  localparam int DEF_KEY_WIDTH   = 8;
  localparam int DEF_VALUE_WIDTH = 64;
  localparam int DEF_TTL_WIDTH   = 32;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PERSIST = 2'd1,
    TIMED   = 2'd2
  } cell_state_t;

  function automatic logic is_live(input cell_state_t s);
    return (s == PERSIST) || (s == TIMED);
  endfunction

endpackage

// File: rtl/dynamic_register_array.sv
// Generic register array: synchronous write, synchronous clear, combinational read of the registered contents.
// Latency: a write is visible on rd_dat the cycle after wr_en.
// Backpressure: none; always accepts a write.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears all entries)
//   clr                 synchronous clear of all entries, wins over wr_en
//   wr_en/wr_addr/wr_dat  write port
//   rd_addr/rd_dat      read port
module dynamic_register_array
  import ttl_memory_cell_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ttl_counter.sv
// Down-counter holding the remaining lifetime of an entry, with zero/one flags for expiry detection.
// Latency: load/dec/clr take effect on the next rising edge; flags are combinational from the count.
// Backpressure: none.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (count -> 0)
//   clr              force count to 0 (highest priority after reset)
//   load, load_val   load a new lifetime
//   dec              decrement by one; saturates at 0, never wraps
//   count            current count (registered)
//   is_zero, is_one  count == 0 / count == 1
module ttl_counter
  import ttl_memory_cell_pkg::*;
#(
  parameter int WIDTH = DEF_TTL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_zero,
  output logic             is_one
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count   = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ttl_memory_cell.sv
// Single key/value cell with optional time-to-live; entry expires after ttl_in ticks, 0 means persistent.
// Latency: writes/deletes/expiry visible one cycle after the op; hit is combinational on the stored state.
// Backpressure: none; every op is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   write_op, delete_op   store key/value/ttl, or invalidate; delete wins over write, write over tick
//   tick                  TTL time-base strobe
//   key_in/value_in/ttl_in  data for write_op (key 0 is reserved and ignored)
//   lookup_key, hit       combinational match against the live stored key
//   key_out/value_out/ttl_out/used_out  registered cell contents
//   expired_pulse         one-cycle pulse in the cycle after a timeout
module ttl_memory_cell
  import ttl_memory_cell_pkg::*;
#(
  parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int TTL_WIDTH   = DEF_TTL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   write_op,
  input  logic                   delete_op,
  input  logic                   tick,
  input  logic [KEY_WIDTH-1:0]   key_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic [TTL_WIDTH-1:0]   ttl_in,
  input  logic [KEY_WIDTH-1:0]   lookup_key,
  output logic                   hit,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic [VALUE_WIDTH-1:0] value_out,
  output logic [TTL_WIDTH-1:0]   ttl_out,
  output logic                   used_out,
  output logic                   expired_pulse
);

  cell_state_t state_q;
  cell_state_t state_d;

  logic do_wr;
  logic do_tick;
  logic expire;
  logic clr_store;
  logic ttl_dec;
  logic ttl_zero;
  logic ttl_one;
  logic pulse_q;

  // Resolve the per-cycle op priority once, so every storage element sees the
  // same decision: delete > write (non-zero key only) > tick.
  assign do_wr   = write_op && (key_in != '0) && !delete_op;
  // ttl_zero is never true while TIMED; guarding on it keeps a corrupted
  // count from turning a tick into a spurious expiry.
  assign do_tick = tick && (state_q == TIMED) && !ttl_zero && !delete_op && !do_wr;
  assign expire  = do_tick && ttl_one;
  // Expiry clears the stored entry exactly like a delete, but also pulses.
  assign clr_store = delete_op || expire;
  // On the final tick the counter is cleared rather than decremented.
  assign ttl_dec   = do_tick && !ttl_one;

  always_comb begin
    state_d = state_q;
    if (delete_op) begin
      state_d = EMPTY;
    end else if (do_wr) begin
      state_d = (ttl_in == '0) ? PERSIST : TIMED;
    end else if (expire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= expire;
    end
  end

  dynamic_register_array #(
    .WIDTH (KEY_WIDTH),
    .DEPTH (1)
  ) u_key_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_store),
    .wr_en   (do_wr),
    .wr_addr (1'b0),
    .wr_dat  (key_in),
    .rd_addr (1'b0),
    .rd_dat  (key_out)
  );

  dynamic_register_array #(
    .WIDTH (VALUE_WIDTH),
    .DEPTH (1)
  ) u_value_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_store),
    .wr_en   (do_wr),
    .wr_addr (1'b0),
    .wr_dat  (value_in),
    .rd_addr (1'b0),
    .rd_dat  (value_out)
  );

  // A write loads ttl_in as-is even if a tick arrives in the same cycle.
  ttl_counter #(
    .WIDTH (TTL_WIDTH)
  ) u_ttl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_store),
    .load     (do_wr),
    .load_val (ttl_in),
    .dec      (ttl_dec),
    .count    (ttl_out),
    .is_zero  (ttl_zero),
    .is_one   (ttl_one)
  );

  assign used_out      = is_live(state_q);
  assign expired_pulse = pulse_q;
  assign hit           = used_out && (lookup_key == key_out) && (lookup_key != '0);

endmodule
